// File: rtl/hiscore_ram_responder_pkg.sv
// Shared constants for the hiscore RAM responder: FSM encodings, default bank
// windows and the value returned for reads that miss both windows.
package hiscore_pkg;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_GRANT   = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    localparam logic [15:0] DEF_BANK0_BASE = 16'h6000;
    localparam int          DEF_BANK0_AW   = 12;
    localparam logic [15:0] DEF_BANK1_BASE = 16'h7400;
    localparam int          DEF_BANK1_AW   = 10;
    localparam int          DEF_SETTLE     = 2;

    localparam logic [7:0] OOB_READ_VAL = 8'hFF;

    typedef enum logic [1:0] {
        SEL_B0   = 2'd0,
        SEL_B1   = 2'd1,
        SEL_NONE = 2'd2
    } rd_sel_e;

endpackage

// File: rtl/hiscore_ram_responder_if.sv
// Hiscore initiator <-> RAM responder access bus.
interface hiscore_ram_if;
    logic        hs_access;
    logic [15:0] hs_address;
    logic [7:0]  hs_data_in;
    logic        hs_write;
    logic [7:0]  hs_data_out;
    logic        hs_grant;

    modport master (
        output hs_access, hs_address, hs_data_in, hs_write,
        input  hs_data_out, hs_grant
    );

    modport slave (
        input  hs_access, hs_address, hs_data_in, hs_write,
        output hs_data_out, hs_grant
    );
endinterface

// File: rtl/hiscore_ram_responder_decode.sv
// Window hit / offset for one RAM bank. The 17-bit subtract makes addresses
// below BASE wrap to huge values, so they never alias into the window.
module hs_window_decode #(
    parameter logic [15:0] BASE = 16'h0000,
    parameter int          AW   = 8
) (
    input  logic [15:0]   addr,
    output logic          hit,
    output logic [AW-1:0] offset
);
    logic [16:0] diff;

    assign diff   = {1'b0, addr} - {1'b0, BASE};
    assign hit    = diff < (17'd1 << AW);
    assign offset = diff[AW-1:0];
endmodule

// File: rtl/hiscore_ram_responder.sv
// Pauses the CPU, muxes the hiscore access bus onto work/video RAM, returns
// registered read data, then hands the RAMs back after a settle period.
module hiscore_ram_responder
    import hiscore_pkg::*;
#(
    parameter logic [15:0] BANK0_BASE = DEF_BANK0_BASE,
    parameter int          BANK0_AW   = DEF_BANK0_AW,
    parameter logic [15:0] BANK1_BASE = DEF_BANK1_BASE,
    parameter int          BANK1_AW   = DEF_BANK1_AW,
    parameter int          SETTLE     = DEF_SETTLE
) (
    input  logic                clk,
    input  logic                reset,
    hiscore_ram_if.slave        hs,
    output logic                cpu_pause_req,
    input  logic                cpu_halted,
    output logic [BANK0_AW-1:0] ram0_addr,
    output logic [7:0]          ram0_din,
    output logic                ram0_we,
    input  logic [7:0]          ram0_dout,
    output logic [BANK1_AW-1:0] ram1_addr,
    output logic [7:0]          ram1_din,
    output logic                ram1_we,
    input  logic [7:0]          ram1_dout,
    output logic                ram_sel_hs,
    output logic                err_oob
);
    localparam int STAGES = 1;
    localparam int CW     = (SETTLE > 2) ? $clog2(SETTLE) : 1;

    logic [1:0]          state, nxt;
    logic [CW-1:0]       cnt;
    logic                grant_q;
    logic [7:0]          data_out_q;
    logic [STAGES:0]     vld_pipe;
    rd_sel_e             sel_pipe [STAGES:0];
    rd_sel_e             rd_sel;

    logic                hit0, hit1;
    logic [BANK0_AW-1:0] off0;
    logic [BANK1_AW-1:0] off1;
    logic                in_grant, go_grant, wr_ok;

    hs_window_decode #(.BASE(BANK0_BASE), .AW(BANK0_AW)) u_dec0 (
        .addr(hs.hs_address), .hit(hit0), .offset(off0)
    );
    hs_window_decode #(.BASE(BANK1_BASE), .AW(BANK1_AW)) u_dec1 (
        .addr(hs.hs_address), .hit(hit1), .offset(off1)
    );

    assign rd_sel   = hit0 ? SEL_B0 : (hit1 ? SEL_B1 : SEL_NONE);
    assign in_grant = (state == S_GRANT);
    assign go_grant = (nxt == S_GRANT);
    // A write issued on the same cycle hs_access drops is discarded.
    assign wr_ok    = in_grant && hs.hs_access && hs.hs_write;

    assign hs.hs_grant    = grant_q;
    assign hs.hs_data_out = data_out_q;

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:    if (hs.hs_access) nxt = S_REQ;
            S_REQ: begin
                if (!hs.hs_access)   nxt = S_IDLE;
                else if (cpu_halted) nxt = S_GRANT;
            end
            S_GRANT:   if (!hs.hs_access) nxt = S_RELEASE;
            S_RELEASE: begin
                // Re-grab skips IDLE so the CPU is never un-paused in between.
                if (hs.hs_access)                 nxt = cpu_halted ? S_GRANT : S_REQ;
                else if (cnt == CW'(SETTLE - 1)) nxt = S_IDLE;
            end
            default:   nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            cnt           <= '0;
            cpu_pause_req <= 1'b0;
            grant_q       <= 1'b0;
            ram_sel_hs    <= 1'b0;
            ram0_addr     <= '0;
            ram0_din      <= '0;
            ram0_we       <= 1'b0;
            ram1_addr     <= '0;
            ram1_din      <= '0;
            ram1_we       <= 1'b0;
            err_oob       <= 1'b0;
            data_out_q    <= OOB_READ_VAL;
            vld_pipe      <= '0;
            for (int i = 0; i <= STAGES; i++) sel_pipe[i] <= SEL_NONE;
        end else begin
            state         <= nxt;
            cnt           <= (state == S_RELEASE && nxt == S_RELEASE) ? cnt + 1'b1 : '0;
            cpu_pause_req <= (nxt != S_IDLE);
            grant_q       <= go_grant;
            ram_sel_hs    <= go_grant;

            // Address also latches on the edge entering GRANT so the first
            // read completes two edges after the grant.
            if (go_grant) begin
                ram0_addr <= off0;
                ram1_addr <= off1;
                ram0_din  <= hs.hs_data_in;
                ram1_din  <= hs.hs_data_in;
            end
            ram0_we <= wr_ok && hit0;
            ram1_we <= wr_ok && !hit0 && hit1;

            if (in_grant && !hit0 && !hit1) err_oob <= 1'b1;

            vld_pipe    <= {vld_pipe[0] && in_grant, go_grant};
            sel_pipe[0] <= rd_sel;
            sel_pipe[1] <= sel_pipe[0];

            if (in_grant && vld_pipe[STAGES]) begin
                case (sel_pipe[STAGES])
                    SEL_B0:  data_out_q <= ram0_dout;
                    SEL_B1:  data_out_q <= ram1_dout;
                    default: data_out_q <= OOB_READ_VAL;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_hiscore_ram_responder.sv
// Directed bench: RAM model, write-event scoreboard monitor and read-data queue.
module tb_hiscore_ram_responder;
    import hiscore_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_halted = 1'b0;
    logic        cpu_pause_req;
    logic [11:0] ram0_addr;
    logic [7:0]  ram0_din, ram0_dout;
    logic        ram0_we;
    logic [9:0]  ram1_addr;
    logic [7:0]  ram1_din, ram1_dout;
    logic        ram1_we;
    logic        ram_sel_hs;
    logic        err_oob;

    logic [7:0] mem0 [0:4095];
    logic [7:0] mem1 [0:1023];

    typedef struct packed {
        logic        b0;
        logic        b1;
        logic [11:0] addr;
        logic [7:0]  din;
    } wr_t;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        valid;
        logic        bank1;
        logic [11:0] off;
    } wvec_t;

    wr_t        wq [$];
    logic [7:0] rdq [$];
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    hiscore_ram_if hs_bus ();

    hiscore_ram_responder dut (
        .clk(clk), .reset(reset), .hs(hs_bus),
        .cpu_pause_req(cpu_pause_req), .cpu_halted(cpu_halted),
        .ram0_addr(ram0_addr), .ram0_din(ram0_din), .ram0_we(ram0_we), .ram0_dout(ram0_dout),
        .ram1_addr(ram1_addr), .ram1_din(ram1_din), .ram1_we(ram1_we), .ram1_dout(ram1_dout),
        .ram_sel_hs(ram_sel_hs), .err_oob(err_oob)
    );

    always @(posedge clk) begin
        if (ram0_we) mem0[ram0_addr] <= ram0_din;
        if (ram1_we) mem1[ram1_addr] <= ram1_din;
        ram0_dout <= mem0[ram0_addr];
        ram1_dout <= mem1[ram1_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_read(input string tag);
        logic [7:0] exp;
        exp = rdq.pop_front();
        check(tag, hs_bus.hs_data_out, exp);
    endtask

    // Every write-enable pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (ram0_we || ram1_we) begin
            wr_t obs;
            obs.b0   = ram0_we;
            obs.b1   = ram1_we;
            obs.addr = ram1_we ? {2'b00, ram1_addr} : ram0_addr;
            obs.din  = ram1_we ? ram1_din : ram0_din;
            check("we_expected", 32'(wq.size() != 0), 32'd1);
            if (wq.size() != 0) check("we_event", 32'(obs), 32'(wq.pop_front()));
        end
    end

    initial begin
        wvec_t wv [7];
        wv[0] = '{16'h6FFF, 8'hA1, 1'b1, 1'b0, 12'hFFF};
        wv[1] = '{16'h7000, 8'hA2, 1'b0, 1'b0, 12'h000};
        wv[2] = '{16'h73FF, 8'hA3, 1'b0, 1'b0, 12'h000};
        wv[3] = '{16'h7400, 8'hA4, 1'b1, 1'b1, 12'h000};
        wv[4] = '{16'h77FF, 8'hA5, 1'b1, 1'b1, 12'h3FF};
        wv[5] = '{16'h7800, 8'hA6, 1'b0, 1'b0, 12'h000};
        wv[6] = '{16'h5FFF, 8'hA7, 1'b0, 1'b0, 12'h000};

        for (int i = 0; i < 4096; i++) mem0[i] = 8'h00;
        for (int i = 0; i < 1024; i++) mem1[i] = 8'h00;
        mem0[12'h100] = 8'h5A;

        hs_bus.hs_access  = 1'b0;
        hs_bus.hs_address = 16'h0000;
        hs_bus.hs_data_in = 8'h00;
        hs_bus.hs_write   = 1'b0;

        // Reset values
        step(2);
        check("rst_grant", hs_bus.hs_grant, 1'b0);
        check("rst_pause", cpu_pause_req, 1'b0);
        check("rst_sel", ram_sel_hs, 1'b0);
        check("rst_we", {ram0_we, ram1_we}, 2'b00);
        check("rst_err", err_oob, 1'b0);
        check("rst_dout", hs_bus.hs_data_out, 8'hFF);
        check("rst_addr", {ram0_addr, ram1_addr}, 22'h0);
        check("rst_din", {ram0_din, ram1_din}, 16'h0);
        reset = 1'b0;
        step();

        // Basic read with delayed halt
        hs_bus.hs_address = 16'h6100;
        hs_bus.hs_access  = 1'b1;
        step();
        check("rd_pause_rise", cpu_pause_req, 1'b1);
        check("rd_grant_wait", hs_bus.hs_grant, 1'b0);
        step(2);
        check("rd_grant_wait2", hs_bus.hs_grant, 1'b0);
        cpu_halted = 1'b1;
        step();
        check("rd_grant", hs_bus.hs_grant, 1'b1);
        check("rd_sel", ram_sel_hs, 1'b1);
        rdq.push_back(8'h5A);
        step();
        check("rd_not_yet", hs_bus.hs_data_out, 8'hFF);
        step();
        check_read("rd_bank0");

        // Single write to bank 1, then read it back
        hs_bus.hs_address = 16'h7410;
        hs_bus.hs_data_in = 8'hC3;
        hs_bus.hs_write   = 1'b1;
        wq.push_back('{1'b0, 1'b1, 12'h010, 8'hC3});
        rdq.push_back(8'hC3);
        step();
        hs_bus.hs_write = 1'b0;
        step();
        check("wr_one_pulse", {ram0_we, ram1_we}, 2'b00);
        step(2);
        check_read("wr_readback");

        // Out of window, with a write that must be dropped
        hs_bus.hs_address = 16'h5000;
        hs_bus.hs_write   = 1'b1;
        rdq.push_back(OOB_READ_VAL);
        step();
        hs_bus.hs_write = 1'b0;
        check("oob_err", err_oob, 1'b1);
        step(2);
        check_read("oob_read");
        hs_bus.hs_address = 16'h6100;
        rdq.push_back(8'h5A);
        step(3);
        check_read("oob_recover");
        check("oob_sticky", err_oob, 1'b1);

        // Window edges
        for (int i = 0; i < 7; i++) begin
            hs_bus.hs_address = wv[i].addr;
            hs_bus.hs_data_in = wv[i].data;
            hs_bus.hs_write   = 1'b1;
            if (wv[i].valid)
                wq.push_back('{!wv[i].bank1, wv[i].bank1, wv[i].off, wv[i].data});
            step();
            hs_bus.hs_write = 1'b0;
            step();
        end
        hs_bus.hs_address = 16'h6FFF;
        rdq.push_back(8'hA1);
        step(3);
        check_read("edge_readback");

        // Release
        hs_bus.hs_access = 1'b0;
        step();
        check("rel_sel", ram_sel_hs, 1'b0);
        check("rel_grant", hs_bus.hs_grant, 1'b0);
        check("rel_pause0", cpu_pause_req, 1'b1);
        step();
        check("rel_pause1", cpu_pause_req, 1'b1);
        step();
        check("rel_pause_drop", cpu_pause_req, 1'b0);
        check("idle_hold", hs_bus.hs_data_out, 8'hA1);

        // Re-grab during RELEASE
        hs_bus.hs_address = 16'h6100;
        hs_bus.hs_access  = 1'b1;
        step(2);
        check("rg_grant", hs_bus.hs_grant, 1'b1);
        hs_bus.hs_access = 1'b0;
        step();
        check("rg_release", hs_bus.hs_grant, 1'b0);
        hs_bus.hs_access = 1'b1;
        rdq.push_back(8'h5A);
        step();
        check("rg_regrant", hs_bus.hs_grant, 1'b1);
        check("rg_no_gap", cpu_pause_req, 1'b1);
        step(2);
        check_read("rg_read");

        // Abort in REQ
        hs_bus.hs_access = 1'b0;
        step(3);
        check("ab_idle", cpu_pause_req, 1'b0);
        cpu_halted = 1'b0;
        hs_bus.hs_access = 1'b1;
        step();
        check("ab_pause", cpu_pause_req, 1'b1);
        step();
        check("ab_nogrant", hs_bus.hs_grant, 1'b0);
        hs_bus.hs_access = 1'b0;
        step();
        check("ab_pause_drop", cpu_pause_req, 1'b0);
        check("ab_nogrant2", {hs_bus.hs_grant, ram_sel_hs}, 2'b00);

        // Reset in GRANT with a write pending
        cpu_halted = 1'b1;
        hs_bus.hs_access = 1'b1;
        step(2);
        check("rs_grant", hs_bus.hs_grant, 1'b1);
        hs_bus.hs_address = 16'h6200;
        hs_bus.hs_data_in = 8'h77;
        hs_bus.hs_write   = 1'b1;
        reset = 1'b1;
        step();
        check("rs_outs", {hs_bus.hs_grant, cpu_pause_req, ram_sel_hs, ram0_we, ram1_we, err_oob}, 6'b0);
        check("rs_dout", hs_bus.hs_data_out, 8'hFF);
        check("rs_addr", {ram0_addr, ram0_din}, 20'h0);
        step();
        reset = 1'b0;
        hs_bus.hs_write  = 1'b0;
        hs_bus.hs_access = 1'b0;
        step(2);
        check("rs_quiet", {ram0_we, ram1_we, hs_bus.hs_grant}, 3'b000);
        check("rs_mem", mem0[12'h200], 8'h00);
        check("wq_drain", wq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
